// File: rtl/pulse_gen_pkg.sv
// Shared types for the programmable down-counting pulse generator.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        PG_IDLE = 2'd0,
        PG_RUN  = 2'd1,
        PG_DONE = 2'd2
    } pg_state_t;

endpackage

// File: rtl/pulse_gen_cfg_shadow.sv
// Period/one-shot configuration registers with a shadow stage so a running
// count is never disturbed by a configuration change.
module pulse_gen_cfg_shadow #(
    parameter int                    WORD_WIDTH   = 8,
    parameter logic [WORD_WIDTH-1:0] RESET_PERIOD = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_valid_i,
    input  logic [WORD_WIDTH-1:0] cfg_period_i,
    input  logic                  cfg_oneshot_i,
    input  logic                  in_run_i,
    input  logic                  apply_i,
    output logic                  cfg_ready_o,
    output logic [WORD_WIDTH-1:0] start_period_o,
    output logic [WORD_WIDTH-1:0] reload_period_o,
    output logic                  oneshot_o
);

    logic [WORD_WIDTH-1:0] period_r;
    logic                  oneshot_r;
    logic [WORD_WIDTH-1:0] shadow_period_r;
    logic                  shadow_oneshot_r;
    logic                  pending_r;
    logic                  xfer_s;

    assign xfer_s      = cfg_valid_i & ~pending_r;
    assign cfg_ready_o = ~pending_r;
    assign oneshot_o   = oneshot_r;

    // Start value: a held shadow, else a same-cycle transfer bypasses the register.
    assign start_period_o  = pending_r ? shadow_period_r :
                             (xfer_s ? cfg_period_i : period_r);
    assign reload_period_o = pending_r ? shadow_period_r : period_r;

    // Outside RUN configuration lands directly; inside RUN it waits in the shadow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            period_r         <= RESET_PERIOD;
            oneshot_r        <= 1'b0;
            shadow_period_r  <= '0;
            shadow_oneshot_r <= 1'b0;
            pending_r        <= 1'b0;
        end else if (!in_run_i) begin
            if (pending_r) begin
                period_r  <= shadow_period_r;
                oneshot_r <= shadow_oneshot_r;
                pending_r <= 1'b0;
            end else if (xfer_s) begin
                period_r  <= cfg_period_i;
                oneshot_r <= cfg_oneshot_i;
            end
        end else begin
            if (apply_i && pending_r) begin
                period_r  <= shadow_period_r;
                oneshot_r <= shadow_oneshot_r;
                pending_r <= 1'b0;
            end else if (xfer_s) begin
                shadow_period_r  <= cfg_period_i;
                shadow_oneshot_r <= cfg_oneshot_i;
                pending_r        <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_gen_binary.sv
// Programmable down-counting pulse generator: emits a one-cycle pulse every
// (period+1) enabled cycles, or once in one-shot mode.
module pulse_gen_binary
    import pulse_gen_pkg::*;
#(
    parameter int                    WORD_WIDTH   = 8,
    parameter logic [WORD_WIDTH-1:0] RESET_PERIOD = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [WORD_WIDTH-1:0] cfg_period_i,
    input  logic                  cfg_oneshot_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  enable_i,
    output logic                  pulse_o,
    output logic [WORD_WIDTH-1:0] count_o,
    output logic                  busy_o,
    output logic                  done_o
);

    pg_state_t             state_r;
    pg_state_t             next_state_s;
    logic [WORD_WIDTH-1:0] count_r;
    logic [WORD_WIDTH-1:0] next_count_s;
    logic                  apply_s;
    logic                  in_run_s;
    logic                  terminal_s;
    logic [WORD_WIDTH-1:0] start_period_s;
    logic [WORD_WIDTH-1:0] reload_period_s;
    logic                  oneshot_s;

    assign in_run_s   = (state_r == PG_RUN);
    assign terminal_s = in_run_s & enable_i & (count_r == '0);
    assign pulse_o    = terminal_s & ~stop_i;
    assign count_o    = count_r;
    assign busy_o     = in_run_s;
    assign done_o     = (state_r == PG_DONE);

    pulse_gen_cfg_shadow #(
        .WORD_WIDTH   (WORD_WIDTH),
        .RESET_PERIOD (RESET_PERIOD)
    ) u_cfg_shadow (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cfg_valid_i     (cfg_valid_i),
        .cfg_period_i    (cfg_period_i),
        .cfg_oneshot_i   (cfg_oneshot_i),
        .in_run_i        (in_run_s),
        .apply_i         (apply_s),
        .cfg_ready_o     (cfg_ready_o),
        .start_period_o  (start_period_s),
        .reload_period_o (reload_period_s),
        .oneshot_o       (oneshot_s)
    );

    // Next-state and down-counter decode; stop always wins.
    always_comb begin
        next_state_s = state_r;
        next_count_s = count_r;
        apply_s      = 1'b0;
        case (state_r)
            PG_IDLE, PG_DONE: begin
                if (stop_i) begin
                    next_state_s = PG_IDLE;
                end else if (start_i) begin
                    next_state_s = PG_RUN;
                    next_count_s = start_period_s;
                end else begin
                    next_state_s = state_r;
                end
            end
            PG_RUN: begin
                if (stop_i) begin
                    next_state_s = PG_IDLE;
                    next_count_s = '0;
                    apply_s      = 1'b1;
                end else if (!enable_i) begin
                    next_count_s = count_r;
                end else if (count_r != '0) begin
                    next_count_s = count_r - WORD_WIDTH'(1);
                end else begin
                    apply_s = 1'b1;
                    if (oneshot_s) begin
                        next_state_s = PG_DONE;
                    end else begin
                        next_count_s = reload_period_s;
                    end
                end
            end
            default: begin
                next_state_s = PG_IDLE;
                next_count_s = '0;
            end
        endcase
    end

    // State and count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= PG_IDLE;
            count_r <= '0;
        end else begin
            state_r <= next_state_s;
            count_r <= next_count_s;
        end
    end

endmodule
